// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the seven-segment scan controller: default build
// parameters, derived widths and the active-low gfedcba segment patterns.
package seg7_scan_display_pkg;

    localparam int DEF_DIGITS   = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_PRESCALE = 4096;

    localparam int SEL_W = $clog2(DEF_CHANNELS);
    localparam int PRE_W = $clog2(DEF_PRESCALE);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern (gfedcba).
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // nibble lookup; default is unreachable for a 4-bit input but keeps the decode total
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0:    o_seg = SEG_0;
            4'h1:    o_seg = SEG_1;
            4'h2:    o_seg = SEG_2;
            4'h3:    o_seg = SEG_3;
            4'h4:    o_seg = SEG_4;
            4'h5:    o_seg = SEG_5;
            4'h6:    o_seg = SEG_6;
            4'h7:    o_seg = SEG_7;
            4'h8:    o_seg = SEG_8;
            4'h9:    o_seg = SEG_9;
            4'hA:    o_seg = SEG_A;
            4'hB:    o_seg = SEG_B;
            4'hC:    o_seg = SEG_C;
            4'hD:    o_seg = SEG_D;
            4'hE:    o_seg = SEG_E;
            4'hF:    o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-channel seven-segment scan controller: per-frame snapshot of the selected
// debug word, prescaled digit scan, leading-zero blanking, decimal points, freeze.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int DIGITS   = DEF_DIGITS,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PRESCALE = DEF_PRESCALE
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CHANNELS*4*DIGITS-1:0]    ch_data,
    input  logic [$clog2(CHANNELS)-1:0]     ch_sel,
    input  logic                            freeze,
    input  logic                            blank_lz,
    input  logic [DIGITS-1:0]               dp_mask,
    output logic [DIGITS-1:0]               en,
    output logic [7:0]                      dis,
    output logic                            frame_done
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    // package widths describe the default build; other builds derive their own
    localparam int SW    = (CHANNELS == DEF_CHANNELS) ? SEL_W : $clog2(CHANNELS);
    localparam int PW    = (PRESCALE == DEF_PRESCALE) ? PRE_W : $clog2(PRESCALE);

    logic [PW-1:0]     r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic [W-1:0]      r_snap;
    logic [DIGITS-1:0] r_en;
    logic [7:0]        r_dis;
    logic              r_frame_done;

    logic              w_tick;
    logic              w_last;
    logic [SW-1:0]     w_sel_eff;
    logic [W-1:0]      w_sel_word;
    logic [3:0]        w_nibble;
    logic [W-1:0]      w_upper;
    logic              w_blank;
    logic [6:0]        w_seg;
    logic [7:0]        w_dis_next;
    logic [DIGITS-1:0] w_en_next;

    assign w_tick     = (r_pre == PW'(PRESCALE - 1));
    assign w_last     = (r_idx == IDX_W'(DIGITS - 1));

    // out-of-range selects fall back to channel 0
    assign w_sel_eff  = (32'(ch_sel) < 32'(CHANNELS)) ? ch_sel : '0;
    assign w_sel_word = ch_data[32'(w_sel_eff) * W +: W];

    assign w_nibble   = r_snap[32'(r_idx) * 4 +: 4];
    assign w_upper    = r_snap >> {r_idx, 2'b00};
    assign w_blank    = blank_lz & (r_idx != '0) & (w_upper == '0);

    hex_to_seg7 u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    assign w_dis_next = {~dp_mask[r_idx], (w_blank ? SEG_BLANK : w_seg)};
    assign w_en_next  = ~(DIGITS'(1) << r_idx);

    // prescaler, digit scan, frame snapshot and registered display outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_snap       <= '0;
            r_en         <= '1;
            r_dis        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + 1'b1;
            r_frame_done <= w_tick & w_last;
            if (w_tick) begin
                r_en  <= w_en_next;
                r_dis <= w_dis_next;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_last && !freeze) begin
                    r_snap <= w_sel_word;
                end
            end
        end
    end

    assign en         = r_en;
    assign dis        = r_dis;
    assign frame_done = r_frame_done;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Parametrised multi-channel seven-segment scan controller, the next generation of the board-level display path. It selects one of CHANNELS debug words (pc, instr, memory probe, …) and snapshots it once per frame so digits never tear. It scans DIGITS digits through an internal refresh prescaler and adds leading-zero blanking, per-digit decimal points and a freeze mode. It sits between the MIPS debug outputs and the board anodes/cathodes and replaces the ad-hoc scan logic in the top level.

Parameters:
DIGITS, 8, number of digits scanned; 2..8; data word width is 4*DIGITS
CHANNELS, 4, number of selectable source words; >=2
PRESCALE, 4096, clk cycles per digit slot; >=2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
ch_data  input  CHANNELS*4*DIGITS  packed source words; channel k = bits [(k+1)*4*DIGITS-1 : k*4*DIGITS]
ch_sel  input  $clog2(CHANNELS)  channel select; values >=CHANNELS select channel 0
freeze  input  1  1 = hold current snapshot, ignore ch_data/ch_sel
blank_lz  input  1  1 = blank leading zero digits
dp_mask  input  DIGITS  decimal point on per digit, active-high
en  output  DIGITS  digit enables, active-low one-hot, registered
dis  output  8  {dp,g,f,e,d,c,b,a}, active-low, registered
frame_done  output  1  one-cycle pulse after the last digit slot of a frame is driven

Behaviour:
- Reset (reset==0 at posedge): pre_cnt=0, idx=0, snapshot=0, en=all ones, dis=8'hFF, frame_done=0. Reset mid-frame aborts the scan immediately; the first slot after release is digit 0.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt==PRESCALE-1).
- On the tick edge: en <= ~(1<<idx); dis <= decode(snapshot nibble idx, blank, dp_mask[idx]); idx <= (idx==DIGITS-1) ? 0 : idx+1. Between ticks, en, dis and idx hold.
- First digit slot appears PRESCALE cycles after reset release. The frame period is DIGITS*PRESCALE cycles.
- Snapshot: on the tick edge with idx==DIGITS-1 and freeze==0, snapshot <= selected channel word. Data changes therefore appear from the next frame (digit 0) onward, never mid-frame. With freeze==1 the snapshot is never updated.
- frame_done: registered 1 on the tick edge with idx==DIGITS-1, 0 otherwise; it is high exactly one cycle.
- Leading-zero blanking (blank_lz==1): digit i is blank when every nibble i..DIGITS-1 of the snapshot is 0 and i!=0. Digit 0 is never blank, so an all-zero word shows a single "0". The blanking decision uses the snapshot, which keeps it stable for the whole frame.
- Blank digit: segments a..g = 1 (off). dp still follows dp_mask.
- Decode (active-low, gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110. dis[7] = ~dp_mask[idx].
- Changes to ch_sel, blank_lz or dp_mask mid-frame: ch_sel takes effect at the next snapshot. blank_lz and dp_mask are sampled at each tick.

Decomposition:
- Shared package: segment encoding constants (SEG_BLANK=7'h7F, hex table) and localparams SEL_W=$clog2(CHANNELS) and PRE_W=$clog2(PRESCALE).
- One sub-module: hex_to_seg7 (combinational 4-bit nibble to 7-bit active-low pattern), instantiated once and fed the nibble muxed by idx.

Test Plan:
- Reset release, DIGITS=8, PRESCALE=4, ch0=32'h0000_0000 -> en=8'hFF and dis=8'hFF for the first 4 cycles; cycle 4 en=8'hFE, dis=8'hC0.
- ch0=32'h1234_ABCD, ch_sel=0, blank_lz=0, dp_mask=0 -> after one frame, the next frame shows digits 0..7 = D,C,B,A,4,3,2,1 (dis=8'hA1,8'hC6,8'h83,8'h88,8'h99,8'hB0,8'hA4,8'hF9); en walks FE,FD,...,7F; frame_done pulses once per 32 cycles.
- ch1=32'h0000_00F0, ch_sel=1, blank_lz=1 -> digits 2..7 dis=8'hFF; digit 1=8'h8E; digit 0=8'hC0. Same data with blank_lz=0 shows 8'hC0 on digits 2..7.
- ch_sel switched 0→1 while idx=3 -> digits 4..7 of the current frame still show channel 0; channel 1 appears from digit 0 of the next frame.
- freeze=1 asserted, then ch0 changed to 32'hFFFF_FFFF -> the display keeps the old word across 3 frames. After freeze=0, the new word appears starting at the next frame boundary.
- reset pulled low while idx=5, held 1 cycle -> the next edge gives en=8'hFF, dis=8'hFF, snapshot=0; the scan restarts at digit 0 after PRESCALE cycles.
- dp_mask=8'h04 -> dis[7]=0 only in digit slot 2, including when that digit is blanked.
